// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU between NUM_REQ
//            requesters, with a registered result on a valid/ready channel.
//            Optional macro ALU_ARB_FAST_ISSUE_EN lets the next grant overlap
//            with the response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OPER_WIDTH = 4,
  parameter int ID_WIDTH   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] req_oper,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [OPER_WIDTH-1:0]      alu_oper,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [ID_WIDTH-1:0]        rsp_id
);

  generate
    if (NUM_REQ > 8 || NUM_REQ < 2) begin : g_bad_num_req
      $error("alu_share_arbiter: NUM_REQ must be in 2..8");
    end
    if (ID_WIDTH < $clog2(NUM_REQ) || ID_WIDTH < 1) begin : g_bad_id_width
      $error("alu_share_arbiter: ID_WIDTH too small for NUM_REQ");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [OPER_WIDTH-1:0] alu_oper_q, alu_oper_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

  logic                  w_grant_found;
  logic [ID_WIDTH-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0]    w_grant_onehot;
  logic                  w_arb_en;
  logic                  w_issue;

  // Scan from farthest to nearest so the nearest valid after rr_ptr wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [ID_WIDTH-1:0] idx;
      idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = idx;
      end
    end
    w_grant_onehot              = '0;
    w_grant_onehot[w_grant_idx] = 1'b1;
  end

`ifdef ALU_ARB_FAST_ISSUE_EN
  assign w_arb_en = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
`else
  assign w_arb_en = (state_q == ST_IDLE);
`endif

  assign w_issue   = w_arb_en && w_grant_found;
  assign req_ready = (w_issue && !rst) ? w_grant_onehot : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    alu_oper_d  = alu_oper_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      ST_EXEC: begin
        rsp_data_d  = alu_data;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A grant overrides the IDLE return taken by an overlapping handshake.
    if (w_issue) begin
      alu_oper_d = req_oper[w_grant_idx*OPER_WIDTH +: OPER_WIDTH];
      alu_a_d    = req_a[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      alu_b_d    = req_b[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      id_d       = w_grant_idx;
      rr_ptr_d   = w_grant_idx;
      state_d    = ST_EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
      id_q        <= '0;
      alu_oper_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      alu_oper_q  <= alu_oper_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign alu_oper  = alu_oper_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Self-checking bench for alu_share_arbiter with an ALU model,
//            directed scenarios and a randomized scoreboard run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int IW = 1;
`ifdef ALU_ARB_FAST_ISSUE_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_LSL = 4'd5, OP_LSR = 4'd6, OP_ASR = 4'd7;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*OW-1:0] req_oper;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [OW-1:0]    alu_oper;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [DW-1:0]    alu_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic [IW-1:0]    rsp_id;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OPER_WIDTH(OW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_oper(req_oper), .req_a(req_a), .req_b(req_b),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_data(alu_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LSL:  return a << b;
      OP_LSR:  return a >> b;
      OP_ASR:  return DW'($signed(a) >>> b);
      default: return '0;
    endcase
  endfunction

  assign alu_data = alu_f(alu_oper, alu_a, alu_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_valid[i]         = 1'b1;
    req_oper[i*OW +: OW] = op;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    req_oper  = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic drain;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_oper  = '1;
    req_a     = '1;
    req_b     = '1;
    rsp_ready = 1'b1;
    repeat (2) tick;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_checks++; if ({alu_oper, alu_a, alu_b} !== '0) $display("FAIL reset_alu: got %h %h %h expected 0", alu_oper, alu_a, alu_b); else n_pass++;
    n_checks++; if ({rsp_data, rsp_id} !== '0) $display("FAIL reset_rsp: got %h %h expected 0", rsp_data, rsp_id); else n_pass++;
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick;
  endtask

  task automatic test_single;
    do_reset;
    set_req(0, OP_ADD, 32'd5, 32'd7);
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b expected 01", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL single_ready_exec: got %b expected 00", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_checks++; if ({alu_oper, alu_a, alu_b} !== {OP_ADD, 32'd5, 32'd7}) $display("FAIL single_alu_in: got %h %h %h expected 0 5 7", alu_oper, alu_a, alu_b); else n_pass++;
    tick;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 32'd12) $display("FAIL single_data: got %0d expected 12", rsp_data); else n_pass++;
    n_checks++; if (rsp_id !== 1'b0) $display("FAIL single_id: got %0d expected 0", rsp_id); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_valid_drop: got %b expected 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_fairness;
    int exp_g = 0;
    int grants = 0;
    int rsps = 0;
    do_reset;
    rsp_ready = 1'b1;
    set_req(0, OP_SUB, 32'd10, 32'd3);
    set_req(1, OP_SUB, 32'd10, 32'd3);
    for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
      #1;
      if (req_ready !== 2'b00) begin
        n_checks++; if (req_ready !== 2'(1 << exp_g)) $display("FAIL fair_order: got %b expected %b", req_ready, 2'(1 << exp_g)); else n_pass++;
        exp_g = 1 - exp_g;
        grants++;
      end
      if (rsp_valid) begin
        n_checks++; if (rsp_data !== 32'd7) $display("FAIL fair_data: got %0d expected 7", rsp_data); else n_pass++;
        rsps++;
      end
      tick;
    end
    n_checks++; if (rsps < 4) $display("FAIL fair_timeout: got %0d responses expected 4", rsps); else n_pass++;
    drain;
  endtask

  task automatic test_backpressure;
    do_reset;
    set_req(1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    #1;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL bp_ready: got %b expected 10", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    set_req(0, OP_ADD, 32'd1, 32'd2);
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'h0000_F000}) $display("FAIL bp_hold: got %b %0d %h expected 1 1 0000f000", rsp_valid, rsp_id, rsp_data); else n_pass++;
      n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_no_ready: got %b expected 00", req_ready); else n_pass++;
      tick;
    end
    rsp_ready = 1'b1;
    #1;
`ifdef ALU_ARB_FAST_ISSUE_EN
    n_checks++; if (req_ready !== 2'b01) $display("FAIL bp_fast_ready: got %b expected 01", req_ready); else n_pass++;
`else
    n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_resp_ready: got %b expected 00", req_ready); else n_pass++;
`endif
    tick;
    req_valid = '0;
    tick;
    #1;
`ifdef ALU_ARB_FAST_ISSUE_EN
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd3}) $display("FAIL bp_fast_rsp: got %b %0d %0d expected 1 0 3", rsp_valid, rsp_id, rsp_data); else n_pass++;
`else
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_dropped_req: got %b expected 0", rsp_valid); else n_pass++;
`endif
    drain;
  endtask

  task automatic test_mid_reset;
    do_reset;
    set_req(1, OP_XOR, 32'h0000_00FF, 32'h0000_000F);
    #1;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL mr_ready: got %b expected 10", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mr_valid_in_rst: got %b expected 0", rsp_valid); else n_pass++;
    tick;
    rst = 1'b0;
    tick;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mr_valid_after: got %b expected 0", rsp_valid); else n_pass++;
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_ADD, 32'd2, 32'd2);
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL mr_first_grant: got %b expected 01", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    tick;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd2}) $display("FAIL mr_rsp: got %b %0d %0d expected 1 0 2", rsp_valid, rsp_id, rsp_data); else n_pass++;
    drain;
  endtask

  task automatic test_shift;
    do_reset;
    set_req(1, OP_ASR, 32'h8000_0000, 32'd40);
    tick;
    req_valid = '0;
    tick;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) $display("FAIL shift_asr: got %b %0d %h expected 1 1 ffffffff", rsp_valid, rsp_id, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    set_req(0, OP_LSL, 32'hFFFF_FFFF, 32'd32);
    repeat (3) tick;
    req_valid = '0;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h0}) $display("FAIL shift_lsl32: got %b %0d %h expected 1 0 00000000", rsp_valid, rsp_id, rsp_data); else n_pass++;
    drain;
  endtask

  task automatic test_back_to_back;
    int g_cyc[$];
    int r_cyc[$];
    do_reset;
    rsp_ready = 1'b1;
    set_req(0, OP_OR, 32'h0000_000F, 32'h0000_00F0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (req_ready[0]) g_cyc.push_back(cyc);
      if (rsp_valid) begin
        r_cyc.push_back(cyc);
        n_checks++; if (rsp_data !== 32'h0000_00FF) $display("FAIL b2b_data: got %h expected 000000ff", rsp_data); else n_pass++;
      end
      tick;
    end
    n_checks++;
    if (g_cyc.size() < 4 || r_cyc.size() < 3) begin
      $display("FAIL b2b_count: got %0d grants %0d rsps expected >=4 >=3", g_cyc.size(), r_cyc.size());
    end else begin
      n_pass++;
      for (int n = 1; n < 4; n++) begin
        n_checks++; if (g_cyc[n] - g_cyc[n-1] !== GAP) $display("FAIL b2b_gap: got %0d expected %0d", g_cyc[n] - g_cyc[n-1], GAP); else n_pass++;
      end
      for (int n = 0; n < 3; n++) begin
        n_checks++; if (r_cyc[n] !== g_cyc[n] + 2) $display("FAIL b2b_latency: got %0d expected %0d", r_cyc[n], g_cyc[n] + 2); else n_pass++;
      end
    end
    drain;
  endtask

  // Scoreboard: pending requests per requester, expected round-robin winner,
  // and a FIFO of expected responses computed from the ALU's definition.
  task automatic test_random;
    logic          pend[NR];
    logic [3:0]    p_op[NR];
    logic [DW-1:0] p_a[NR];
    logic [DW-1:0] p_b[NR];
    int            exp_id[$];
    logic [DW-1:0] exp_data[$];
    int            last = NR - 1;
    int            grants = 0;
    logic          held = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic [IW-1:0] held_id = '0;
    do_reset;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      int granted = -1;
      for (int i = 0; i < NR; i++) begin
        if (cyc < 450 && !pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          p_op[i] = 4'($urandom_range(0, 7));
          p_a[i]  = $urandom;
          p_b[i]  = ($urandom_range(0, 2) == 0) ? $urandom : DW'($urandom_range(0, 40));
        end
        req_valid[i]         = pend[i];
        req_oper[i*OW +: OW] = p_op[i];
        req_a[i*DW +: DW]    = p_a[i];
        req_b[i*DW +: DW]    = p_b[i];
      end
      rsp_ready = (cyc >= 450) || ($urandom_range(0, 3) != 0);
      #1;
      if (rsp_valid) begin
        if (held) begin
          n_checks++; if ({rsp_data, rsp_id} !== {held_data, held_id}) $display("FAIL rnd_stable: got %h %0d expected %h %0d", rsp_data, rsp_id, held_data, held_id); else n_pass++;
        end
        if (!rsp_ready) begin
          n_checks++; if (req_ready !== '0) $display("FAIL rnd_ready_in_bp: got %b expected 0", req_ready); else n_pass++;
        end
`ifndef ALU_ARB_FAST_ISSUE_EN
        n_checks++; if (req_ready !== '0) $display("FAIL rnd_ready_in_resp: got %b expected 0", req_ready); else n_pass++;
`endif
        if (rsp_ready) begin
          n_checks++;
          if (exp_id.size() == 0) begin
            $display("FAIL rnd_spurious_rsp: got %h %0d expected no response", rsp_data, rsp_id);
          end else begin
            int            e_id = exp_id.pop_front();
            logic [DW-1:0] e_d  = exp_data.pop_front();
            if ({rsp_data, rsp_id} !== {e_d, IW'(e_id)}) $display("FAIL rnd_rsp: got %h %0d expected %h %0d", rsp_data, rsp_id, e_d, e_id);
            else n_pass++;
          end
        end
      end
      held      = rsp_valid && !rsp_ready;
      held_data = rsp_data;
      held_id   = rsp_id;
      if (req_ready !== '0) begin
        int          e = -1;
        logic [NR-1:0] oh = '0;
        for (int k = 1; k <= NR; k++) if (e < 0 && pend[(last + k) % NR]) e = (last + k) % NR;
        n_checks++;
        if (e < 0) begin
          $display("FAIL rnd_grant_none: got %b expected 0", req_ready);
        end else begin
          oh[e] = 1'b1;
          if (req_ready !== oh) $display("FAIL rnd_grant: got %b expected %b", req_ready, oh);
          else n_pass++;
          exp_id.push_back(e);
          exp_data.push_back(alu_f(p_op[e], p_a[e], p_b[e]));
          last    = e;
          granted = e;
          grants++;
        end
      end
      tick;
      if (granted >= 0) pend[granted] = 1'b0;
    end
    n_checks++; if (exp_id.size() != 0) $display("FAIL rnd_lost: got %0d outstanding expected 0", exp_id.size()); else n_pass++;
    n_checks++; if (grants < 60) $display("FAIL rnd_throughput: got %0d grants expected >=60", grants); else n_pass++;
    drain;
  endtask

  initial begin
    req_valid = '0;
    req_oper  = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_mid_reset;
    test_shift;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
